instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer that drives the processor's instruction flow.
- Fetches 10-bit instructions (format iiiidddddd) from instruction memory over a req/ack handshake.
- Holds the instruction register and owns the program counter, including JMP.
- Issues a one-cycle execute strobe that gates datapath and register-file writes.
- Supports free-run, single-step, halt and fetch-timeout fault; sits between instruction memory and the control unit/datapath.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/instr_sequencer.sv | 144 ++++++++++++++
 tb/tb_instr_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared states, opcodes and instruction fields for the
//                instruction sequencer and control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        NEXT   = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    localparam int INSTR_W = 10;

    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_HLT  = 4'b1111;
    localparam logic [3:0] OP_ILL0 = 4'b1101;
    localparam logic [3:0] OP_ILL1 = 4'b1110;

    localparam int OPC_HI = 9;
    localparam int OPC_LO = 6;
    localparam int OPD_HI = 5;
    localparam int OPD_LO = 0;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [5:0] get_operand(input logic [INSTR_W-1:0] instr);
        return instr[OPD_HI:OPD_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch/decode/execute sequencer owning the PC and IR, with
//                free-run, single-step, halt and fetch-timeout fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 64,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_global,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [9:0]         imem_data,
    output logic [9:0]         ir,
    output logic               ir_valid,
    output logic               exec_en,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [9:0]         r_ir;
    logic [CNT_W-1:0]   r_count;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_step_pending;
    logic [3:0]         w_opcode;
    logic               w_tmo_expire;

    assign w_opcode     = get_opcode(r_ir);
    assign w_tmo_expire = (r_tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (halt_req)
                    w_next = HALT;
                else if (run || r_step_pending)
                    w_next = FETCH;
            end
            FETCH:  w_next = WAIT;
            WAIT: begin
                if (imem_ack)
                    w_next = DECODE;
                else if (w_tmo_expire)
                    w_next = FAULT;
            end
            DECODE: begin
                if (w_opcode == OP_HLT)
                    w_next = HALT;
                else if (w_opcode == OP_ILL0 || w_opcode == OP_ILL1)
                    w_next = FAULT;
                else
                    w_next = EXEC;
            end
            EXEC:   w_next = NEXT;
            NEXT: begin
                if (halt_req)
                    w_next = HALT;
                else if (run)
                    w_next = FETCH;
                else
                    w_next = IDLE;
            end
            HALT:   w_next = HALT;
            FAULT:  w_next = FAULT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_state        <= IDLE;
            r_pc           <= '0;
            r_ir           <= '0;
            r_count        <= '0;
            r_tmo_cnt      <= '0;
            r_step_pending <= 1'b0;
        end else begin
            r_state <= w_next;

            // A step is consumed by the fetch it launches.
            if (r_state == IDLE && w_next == FETCH)
                r_step_pending <= 1'b0;
            else if (step)
                r_step_pending <= 1'b1;

            case (r_state)
                FETCH: r_tmo_cnt <= '0;
                WAIT: begin
                    if (imem_ack)
                        r_ir <= imem_data;
                    else
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                EXEC: begin
                    if (r_count != {CNT_W{1'b1}})
                        r_count <= r_count + CNT_W'(1);
                end
                NEXT: begin
                    // Jump targets beyond the program length are taken verbatim.
                    if (w_opcode == OP_JMP)
                        r_pc <= PC_W'(get_operand(r_ir));
                    else if (r_pc == PC_W'(PROG_LEN - 1))
                        r_pc <= '0;
                    else
                        r_pc <= r_pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH) || (r_state == WAIT);
    assign imem_addr   = r_pc;
    assign ir          = r_ir;
    assign ir_valid    = (r_state == DECODE) || (r_state == EXEC) || (r_state == NEXT);
    assign exec_en     = (r_state == EXEC);
    assign pc          = r_pc;
    assign state       = r_state;
    assign halted      = (r_state == HALT);
    assign fault       = (r_state == FAULT);
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed self-checking bench for instr_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam logic [9:0] I_ADD  = 10'b0000_000001;
    localparam logic [9:0] I_SUB  = 10'b0001_000010;
    localparam logic [9:0] I_ADDI = 10'b0010_000011;
    localparam logic [9:0] I_HLT  = 10'b1111_000000;

    logic        clk = 1'b0;
    logic        reset_global = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [9:0]  imem_data;
    logic [9:0]  ir;
    logic        ir_valid;
    logic        exec_en;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;

    logic [9:0]  mem [0:255];
    logic        ack_en = 1'b1;
    logic        r_seen;

    int errors = 0;
    int checks = 0;
    int exec_cyc[$];
    logic [7:0] fetch_addr[$];

    instr_sequencer #(.PC_W(8), .PROG_LEN(64), .TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .reset_global(reset_global), .run(run), .step(step),
        .halt_req(halt_req), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
        .exec_en(exec_en), .pc(pc), .state(state), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Memory answers in the first WAIT cycle (request already seen last cycle).
    always @(posedge clk or posedge reset_global) begin
        if (reset_global) r_seen <= 1'b0;
        else              r_seen <= imem_req;
    end
    assign imem_ack  = ack_en & imem_req & r_seen;
    assign imem_data = mem[imem_addr];

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = I_ADD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_global = 1'b1;
        run = 1'b0; step = 1'b0; halt_req = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        reset_global = 1'b0;
    endtask

    task automatic run_until(input int budget, input bit stop_idle, output bit timed_out);
        bit left;
        left = 1'b0;
        timed_out = 1'b1;
        exec_cyc.delete();
        fetch_addr.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (exec_en) exec_cyc.push_back(cyc);
            if (state == 3'd1) fetch_addr.push_back(imem_addr);
            if (state != 3'd0) left = 1'b1;
            if (halted || fault || (stop_idle && left && state == 3'd0)) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_global = 1'b1;
        #1;
        checks++;
        if ({state, pc, ir, instr_count} !== {3'd0, 8'd0, 10'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_regs: state=%0d pc=%0d ir=%h cnt=%0d, required all 0", state, pc, ir, instr_count);
        end
        checks++;
        if ({imem_req, ir_valid, exec_en, halted, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_bits: req/irv/exec/halt/fault=%b, required 00000",
                     {imem_req, ir_valid, exec_en, halted, fault});
        end
        @(negedge clk);
        reset_global = 1'b0;
    endtask

    task automatic test_run_seq();
        bit to;
        fill_mem();
        mem[0] = I_ADD; mem[1] = I_SUB; mem[2] = I_ADDI; mem[3] = I_HLT;
        do_reset();
        run = 1'b1;
        run_until(100, 1'b0, to);
        run = 1'b0;
        checks++;
        if (to) begin errors++; $display("FAIL run_seq_timeout: never halted, required halt"); end
        checks++;
        if (exec_cyc.size() != 3) begin
            errors++; $display("FAIL run_seq_execs: got %0d exec pulses, required 3", exec_cyc.size());
        end else begin
            checks++;
            if (exec_cyc[1] - exec_cyc[0] != 5 || exec_cyc[2] - exec_cyc[1] != 5) begin
                errors++;
                $display("FAIL run_seq_spacing: gaps %0d,%0d, required 5,5",
                         exec_cyc[1] - exec_cyc[0], exec_cyc[2] - exec_cyc[1]);
            end
        end
        checks++;
        if (fetch_addr.size() != 4 || fetch_addr[0] != 8'd0 || fetch_addr[1] != 8'd1 ||
            fetch_addr[2] != 8'd2 || fetch_addr[3] != 8'd3) begin
            errors++; $display("FAIL run_seq_addrs: %p, required 0,1,2,3", fetch_addr);
        end
        checks++;
        if (pc !== 8'd3 || instr_count !== 16'd3 || halted !== 1'b1 || ir !== I_HLT) begin
            errors++;
            $display("FAIL run_seq_end: pc=%0d cnt=%0d halted=%b ir=%h, required 3,3,1,3c0",
                     pc, instr_count, halted, ir);
        end
        // HALT is sticky and frozen even with run raised again.
        run = 1'b1;
        repeat (4) @(negedge clk);
        run = 1'b0;
        checks++;
        if (state !== 3'd6 || pc !== 8'd3 || instr_count !== 16'd3 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: state=%0d pc=%0d cnt=%0d req=%b, required 6,3,3,0",
                     state, pc, instr_count, imem_req);
        end
    endtask

    task automatic test_jmp();
        bit to;
        fill_mem();
        mem[0] = 10'b1001_000101; mem[5] = I_HLT;
        do_reset();
        run = 1'b1;
        run_until(100, 1'b0, to);
        run = 1'b0;
        checks++;
        if (to || fetch_addr.size() != 2 || fetch_addr[0] != 8'd0 || fetch_addr[1] != 8'd5) begin
            errors++; $display("FAIL jmp_addrs: to=%b %p, required 0,5", to, fetch_addr);
        end
        checks++;
        if (pc !== 8'd5 || instr_count !== 16'd1 || exec_cyc.size() != 1) begin
            errors++;
            $display("FAIL jmp_end: pc=%0d cnt=%0d execs=%0d, required 5,1,1", pc, instr_count, exec_cyc.size());
        end
    endtask

    task automatic test_step();
        bit to;
        fill_mem();
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); step = 1'b1;
            @(negedge clk); step = 1'b0;
            run_until(30, 1'b1, to);
            checks++;
            if (to || state !== 3'd0 || exec_cyc.size() != 1 || fetch_addr.size() != 1) begin
                errors++;
                $display("FAIL step%0d_single: to=%b state=%0d execs=%0d fetches=%0d, required 0,0,1,1",
                         k, to, state, exec_cyc.size(), fetch_addr.size());
            end
            checks++;
            if (pc !== 8'(k) || instr_count !== 16'(k)) begin
                errors++;
                $display("FAIL step%0d_pc: pc=%0d cnt=%0d, required %0d,%0d", k, pc, instr_count, k, k);
            end
        end
        // Idle without a step must not fetch.
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 3'd0 || pc !== 8'd2) begin
            errors++; $display("FAIL step_idle: state=%0d pc=%0d, required 0,2", state, pc);
        end
    endtask

    task automatic test_wrap();
        bit to;
        fill_mem();
        mem[0] = 10'b1001_111111;
        do_reset();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        run_until(30, 1'b1, to);
        checks++;
        if (to || pc !== 8'd63) begin
            errors++; $display("FAIL wrap_jmp63: to=%b pc=%0d, required pc 63", to, pc);
        end
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        run_until(30, 1'b1, to);
        checks++;
        if (to || pc !== 8'd0 || instr_count !== 16'd2) begin
            errors++; $display("FAIL wrap_pc: to=%b pc=%0d cnt=%0d, required 0,2", to, pc, instr_count);
        end
    endtask

    task automatic test_timeout();
        int waits;
        bit done;
        fill_mem();
        do_reset();
        ack_en = 1'b0;
        run = 1'b1;
        waits = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (state == 3'd2) waits++;
            if (state == 3'd7) done = 1'b1;
        end
        run = 1'b0;
        checks++;
        if (!done || waits != 15) begin
            errors++; $display("FAIL timeout_waits: reached=%b wait_cycles=%0d, required 1,15", done, waits);
        end
        checks++;
        if (state !== 3'd7 || fault !== 1'b1 || imem_req !== 1'b0 || exec_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: state=%0d fault=%b req=%b exec=%b, required 7,1,0,0",
                     state, fault, imem_req, exec_en);
        end
        do_reset();
        #1;
        checks++;
        if (state !== 3'd0 || pc !== 8'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL timeout_reset: state=%0d pc=%0d fault=%b, required 0,0,0", state, pc, fault);
        end
    endtask

    task automatic test_illegal();
        bit to;
        fill_mem();
        mem[0] = 10'b1101_000000;
        do_reset();
        run = 1'b1;
        run_until(40, 1'b0, to);
        run = 1'b0;
        checks++;
        if (to || fault !== 1'b1 || state !== 3'd7 || exec_cyc.size() != 0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL illegal_op: to=%b fault=%b state=%0d execs=%0d cnt=%0d, required 0,1,7,0,0",
                     to, fault, state, exec_cyc.size(), instr_count);
        end
    endtask

    task automatic test_hlt();
        bit to;
        fill_mem();
        mem[2] = I_HLT;
        do_reset();
        run = 1'b1;
        run_until(60, 1'b0, to);
        run = 1'b0;
        checks++;
        if (to || halted !== 1'b1 || pc !== 8'd2 || exec_cyc.size() != 2 || instr_count !== 16'd2) begin
            errors++;
            $display("FAIL hlt_op: to=%b halted=%b pc=%0d execs=%0d cnt=%0d, required 0,1,2,2,2",
                     to, halted, pc, exec_cyc.size(), instr_count);
        end
    endtask

    task automatic test_halt_req();
        bit to;
        bit seen_wait;
        fill_mem();
        do_reset();
        run = 1'b1;
        seen_wait = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_wait; cyc++) begin
            @(negedge clk);
            if (state == 3'd2) seen_wait = 1'b1;
        end
        halt_req = 1'b1;
        run_until(40, 1'b0, to);
        halt_req = 1'b0;
        run = 1'b0;
        checks++;
        if (!seen_wait || to || halted !== 1'b1 || exec_cyc.size() != 1) begin
            errors++;
            $display("FAIL halt_req_exec: wait=%b to=%b halted=%b execs=%0d, required 1,0,1,1",
                     seen_wait, to, halted, exec_cyc.size());
        end
        checks++;
        if (pc !== 8'd1 || instr_count !== 16'd1) begin
            errors++; $display("FAIL halt_req_pc: pc=%0d cnt=%0d, required 1,1", pc, instr_count);
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_run_seq();
        test_jmp();
        test_step();
        test_wrap();
        test_timeout();
        test_illegal();
        test_hlt();
        test_halt_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
